jtgng_inputs: RTL

JTGNG_INPUTS -- requirements
Module: jtgng_inputs

---
 rtl/jtgng_inputs.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/jtgng_inputs.sv
// jtgng_inputs: merges PS/2 keys with pad bits, adds autofire,
// coin pulse generation and a pause toggle for arcade controls.
module jtgng_inputs #(
  parameter int          PLAYERS     = 2,
  parameter int          BUTTONS     = 2,
  parameter logic [15:0] COIN_CYCLES = 16'd2400,
  parameter logic [15:0] AF_DIV      = 16'd50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joy_raw,
  input  logic                         pause_clr,
  input  logic [PLAYERS-1:0]           autofire_en,
  output logic [(4+BUTTONS)*PLAYERS-1:0] joystick_n,
  output logic [PLAYERS-1:0]           start_n,
  output logic [PLAYERS-1:0]           coin_n,
  output logic                         pause,
  output logic                         test_n
);

  localparam int JW = 4 + BUTTONS;

  typedef enum logic {C_IDLE, C_PULSE} coin_st_t;

  // key bits: 0 right,1 left,2 down,3 up,4/5 btn0,6 btn1,
  // 7 start0,8 start1,9 coin0,10 pause,11 test
  logic        r_ps2_tog;
  logic [11:0] r_key;
  logic [11:0] w_key_nxt;
  logic        w_kev;
  logic [7:0]  w_code;
  logic        w_prs;

  assign w_kev  = ps2_key[10] ^ r_ps2_tog;
  assign w_code = ps2_key[7:0];
  assign w_prs  = ps2_key[9];

  always_comb begin
    w_key_nxt = r_key;
    if (w_kev) begin
      unique case (1'b1)
        (w_code == 8'h74): w_key_nxt[0]  = w_prs;
        (w_code == 8'h6B): w_key_nxt[1]  = w_prs;
        (w_code == 8'h72): w_key_nxt[2]  = w_prs;
        (w_code == 8'h75): w_key_nxt[3]  = w_prs;
        (w_code == 8'h14): w_key_nxt[4]  = w_prs;
        (w_code == 8'h11): w_key_nxt[5]  = w_prs;
        (w_code == 8'h29): w_key_nxt[6]  = w_prs;
        (w_code == 8'h05): w_key_nxt[7]  = w_prs;
        (w_code == 8'h06): w_key_nxt[8]  = w_prs;
        (w_code == 8'h04): w_key_nxt[9]  = w_prs;
        (w_code == 8'h0C): w_key_nxt[10] = w_prs;
        (w_code == 8'h03): w_key_nxt[11] = w_prs;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps2_tog <= 1'b0;
      r_key     <= '0;
    end else begin
      r_ps2_tog <= ps2_key[10];
      r_key     <= w_key_nxt;
    end
  end

  logic [15:0] r_af_cnt;
  logic        r_af_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AF_DIV - 16'd1) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 16'd1;
    end
  end

  logic w_preq;
  logic r_pause_prev;
  logic r_pause;
  logic r_test_n;

  always_comb begin
    w_preq = w_key_nxt[10];
    for (int p = 0; p < PLAYERS; p++)
      w_preq = w_preq | joy_raw[16*p+12];
  end

  // clear wins over a simultaneous toggle edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pause_prev <= 1'b0;
      r_pause      <= 1'b0;
      r_test_n     <= 1'b1;
    end else begin
      r_pause_prev <= w_preq;
      r_test_n     <= ~w_key_nxt[11];
      if (pause_clr)
        r_pause <= 1'b0;
      else if (w_preq && !r_pause_prev)
        r_pause <= ~r_pause;
    end
  end

  assign pause  = r_pause;
  assign test_n = r_test_n;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [15:0]        w_pad;
    logic [JW-1:0]      w_req;
    logic [BUTTONS-1:0] w_kbtn;
    logic               w_start;
    logic               w_coin;
    logic [JW-1:0]      r_joy_n;
    logic               r_start_n;
    coin_st_t           r_st;
    coin_st_t           w_st_nxt;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_nxt;
    logic               r_prev;
    logic               r_arm;

    assign w_pad = joy_raw[16*p +: 16];

    always_comb begin
      w_kbtn  = '0;
      w_start = w_pad[10];
      w_coin  = w_pad[11];
      w_req   = w_pad[JW-1:0];
      if (p == 0) begin
        w_kbtn[0] = w_key_nxt[4] | w_key_nxt[5];
        for (int b = 1; b < BUTTONS; b++)
          if (b == 1) w_kbtn[b] = w_key_nxt[6];
        w_req[3:0] = w_req[3:0] | w_key_nxt[3:0];
        w_start    = w_start | w_key_nxt[7];
        w_coin     = w_coin | w_key_nxt[9];
      end
      if (p == 1) w_start = w_start | w_key_nxt[8];
      w_req[JW-1:4] = w_req[JW-1:4] | w_kbtn;
      if (autofire_en[p]) w_req[4] = w_req[4] & r_af_phase;
    end

    always_comb begin
      w_st_nxt  = r_st;
      w_cnt_nxt = r_cnt;
      unique case (r_st)
        C_IDLE: begin
          if (w_coin && !r_prev && r_arm) begin
            w_st_nxt  = C_PULSE;
            w_cnt_nxt = '0;
          end
        end
        C_PULSE: begin
          if (r_cnt == COIN_CYCLES - 16'd1)
            w_st_nxt  = C_IDLE;
          else
            w_cnt_nxt = r_cnt + 16'd1;
        end
        default: w_st_nxt = C_IDLE;
      endcase
    end

    // r_arm stays low after reset until the request is seen low
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_joy_n   <= '1;
        r_start_n <= 1'b1;
        r_st      <= C_IDLE;
        r_cnt     <= '0;
        r_prev    <= 1'b0;
        r_arm     <= 1'b0;
      end else begin
        r_joy_n   <= ~w_req;
        r_start_n <= ~w_start;
        r_st      <= w_st_nxt;
        r_cnt     <= w_cnt_nxt;
        r_prev    <= w_coin;
        r_arm     <= r_arm | ~w_coin;
      end
    end

    assign joystick_n[JW*p +: JW] = r_joy_n;
    assign start_n[p]             = r_start_n;
    assign coin_n[p]              = (r_st != C_PULSE);
  end

endmodule
